// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the dual-issue instruction fetch unit.
package inst_fetch_unit_pkg;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam int BR_WD = 33;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] inst;
    logic [1:0]  slot_val;
  } fetch_out_t;

  function automatic logic [31:0] align8(input logic [31:0] a);
    return {a[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// SRAM request/response handshake plus the fetch-to-ID valid/ready channel.
interface inst_fetch_unit_if;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [63:0] inst_sram_rdata;

  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic [63:0] fetch_inst;
  logic [1:0]  fetch_slot_val;
  logic        fetch_adel;

  modport master (
    output inst_sram_req, inst_sram_addr,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output fetch_valid, fetch_pc, fetch_inst, fetch_slot_val, fetch_adel,
    input  fetch_ready
  );

  modport slave (
    input  inst_sram_req, inst_sram_addr,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  fetch_valid, fetch_pc, fetch_inst, fetch_slot_val, fetch_adel,
    output fetch_ready
  );
endinterface

// File: rtl/inst_fetch_unit_pc_gen.sv
// Fetch PC register with flush > branch > sequential next-PC selection.
module inst_fetch_unit_pc_gen
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter int          FLUSH_PC_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [FLUSH_PC_W-1:0] flush_pc,
  input  logic [BR_WD-1:0]      br_bus,
  input  logic                  br_en,
  input  logic                  seq_adv,
  output logic [31:0]           pc_q,
  output logic                  redirect,
  output logic                  misaligned
);

  logic [31:0] pc_d;

  assign redirect   = flush | (br_en & br_bus[32]);
  assign misaligned = |pc_q[1:0];

  always_comb begin
    if (flush)                   pc_d = 32'(flush_pc);
    else if (br_en && br_bus[32]) pc_d = br_bus[31:0];
    else if (seq_adv)            pc_d = align8(pc_q) + 32'd8;
    else                         pc_d = pc_q;
  end

  // NOTE: state updates use <= so every flop samples pre-edge values; reset is async active-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch-side producer: issues SRAM requests, cancels stale responses on redirect,
// and holds each instruction pair until the ID buffer accepts it.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter int          FLUSH_PC_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_if,
  input  logic                  flush,
  input  logic [FLUSH_PC_W-1:0] flush_pc,
  input  logic [BR_WD-1:0]      br_bus,
  inst_fetch_unit_if.master     bus
);

  logic [1:0]  state_q, state_d;
  logic        cancel_q, cancel_d;
  logic [31:0] pc_inflight_q, pc_inflight_d;
  fetch_out_t  out_q, out_d;
  logic        req_en_q;

  logic [31:0] pc;
  logic        redirect, misaligned, req, seq_adv, br_en;

  // A faulted fetch only leaves S_ERR on flush, so branches are ignored there.
  assign br_en   = (state_q != S_ERR);
  assign req     = (state_q == S_REQ) & req_en_q & ~stall_if & ~misaligned;
  assign seq_adv = req & bus.inst_sram_addr_ok & ~redirect;

  inst_fetch_unit_pc_gen #(
    .RESET_PC   (RESET_PC),
    .FLUSH_PC_W (FLUSH_PC_W)
  ) u_pc_gen (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .br_bus     (br_bus),
    .br_en      (br_en),
    .seq_adv    (seq_adv),
    .pc_q       (pc),
    .redirect   (redirect),
    .misaligned (misaligned)
  );

  // NOTE: every always_comb target gets a default first so no latch can be inferred.
  always_comb begin
    state_d       = state_q;
    cancel_d      = cancel_q;
    pc_inflight_d = pc_inflight_q;
    out_d         = out_q;
    case (state_q)
      S_REQ: begin
        if (misaligned && !redirect) begin
          state_d = S_ERR;
          out_d   = '{pc: pc, inst: '0, slot_val: 2'b01};
        end else if (req && bus.inst_sram_addr_ok) begin
          pc_inflight_d = pc;
          cancel_d      = redirect;
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.inst_sram_data_ok) begin
          if (cancel_q || redirect) begin
            cancel_d = 1'b0;
            state_d  = S_REQ;
          end else begin
            out_d = '{pc:       align8(pc_inflight_q),
                      inst:     bus.inst_sram_rdata,
                      slot_val: pc_inflight_q[2] ? 2'b10 : 2'b11};
            state_d = S_HOLD;
          end
        end else if (redirect) begin
          cancel_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect || bus.fetch_ready) state_d = S_REQ;
      end
      default: begin
        if (flush) state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_REQ;
      cancel_q      <= 1'b0;
      pc_inflight_q <= '0;
      out_q         <= '0;
      req_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cancel_q      <= cancel_d;
      pc_inflight_q <= pc_inflight_d;
      out_q         <= out_d;
      req_en_q      <= 1'b1;
    end
  end

  // Outputs come from state and registers only; nothing is combinational on fetch_ready.
  assign bus.inst_sram_req  = req;
  assign bus.inst_sram_addr = align8(pc);
  assign bus.fetch_valid    = (state_q == S_HOLD) || (state_q == S_ERR);
  assign bus.fetch_adel     = (state_q == S_ERR);
  assign bus.fetch_pc       = out_q.pc;
  assign bus.fetch_inst     = out_q.inst;
  assign bus.fetch_slot_val = out_q.slot_val;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed-vector bench for inst_fetch_unit with a hand-driven SRAM and ID buffer.
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_if = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic [32:0] br_bus = '0;

  int n_checks = 0;
  int n_pass   = 0;

  inst_fetch_unit_if bus ();

  inst_fetch_unit #(.RESET_PC(32'hBFC0_0000), .FLUSH_PC_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .stall_if (stall_if),
    .flush    (flush),
    .flush_pc (flush_pc),
    .br_bus   (br_bus),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {(a + 32'd4) ^ 32'h1234_5678, a ^ 32'h1234_5678};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a);
    check("req", bus.inst_sram_req, 1);
    check("addr", bus.inst_sram_addr, a);
    bus.inst_sram_addr_ok = 1'b1;
    tick();
    bus.inst_sram_addr_ok = 1'b0;
    check("req_in_wait", bus.inst_sram_req, 0);
  endtask

  task automatic respond(input logic [31:0] a, input logic [1:0] slot);
    bus.inst_sram_data_ok = 1'b1;
    bus.inst_sram_rdata   = pat(a);
    tick();
    bus.inst_sram_data_ok = 1'b0;
    check("valid", bus.fetch_valid, 1);
    check("fetch_pc", bus.fetch_pc, a);
    check("fetch_inst", bus.fetch_inst, pat(a));
    check("slot_val", bus.fetch_slot_val, slot);
  endtask

  task automatic accept();
    bus.fetch_ready = 1'b1;
    tick();
    bus.fetch_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, bus.inst_sram_req, 0);
    check({tag, "_addr"}, bus.inst_sram_addr, 32'hBFC0_0000);
    check({tag, "_valid"}, bus.fetch_valid, 0);
    check({tag, "_pc"}, bus.fetch_pc, 0);
    check({tag, "_inst"}, bus.fetch_inst, 0);
    check({tag, "_slot"}, bus.fetch_slot_val, 0);
    check({tag, "_adel"}, bus.fetch_adel, 0);
  endtask

  initial begin
    logic [63:0] held;
    bus.inst_sram_addr_ok = 1'b0;
    bus.inst_sram_data_ok = 1'b0;
    bus.inst_sram_rdata   = '0;
    bus.fetch_ready       = 1'b0;

    // Reset
    #1 rst = 1'b0;
    #1 check_all_zero("reset");
    @(posedge clk);
    tick();
    rst = 1'b1;
    tick();

    // Free-run sequential fetches
    issue(32'hBFC0_0000); respond(32'hBFC0_0000, 2'b11); accept();
    issue(32'hBFC0_0008); respond(32'hBFC0_0008, 2'b11); accept();
    issue(32'hBFC0_0010); respond(32'hBFC0_0010, 2'b11); accept();

    // Backpressure in S_HOLD
    issue(32'hBFC0_0018); respond(32'hBFC0_0018, 2'b11);
    held = bus.fetch_inst;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", bus.fetch_valid, 1);
      check("bp_inst", bus.fetch_inst, held);
      check("bp_req", bus.inst_sram_req, 0);
    end
    accept();

    // Branch while waiting: late response dropped
    issue(32'hBFC0_0020);
    br_bus = {1'b1, 32'h8000_1004};
    tick();
    br_bus = '0;
    check("brw_valid", bus.fetch_valid, 0);
    tick();
    bus.inst_sram_data_ok = 1'b1;
    bus.inst_sram_rdata   = pat(32'hBFC0_0020);
    tick();
    bus.inst_sram_data_ok = 1'b0;
    check("brw_drop_valid", bus.fetch_valid, 0);
    issue(32'h8000_1000); respond(32'h8000_1000, 2'b10); accept();

    // Flush beats branch in the same cycle
    flush = 1'b1; flush_pc = 32'hBFC0_0380; br_bus = {1'b1, 32'h8000_0000};
    tick();
    flush = 1'b0; br_bus = '0;
    issue(32'hBFC0_0380); respond(32'hBFC0_0380, 2'b11); accept();

    // Branch coincident with addr_ok: the accepted request is cancelled
    bus.inst_sram_addr_ok = 1'b1;
    br_bus = {1'b1, 32'h8000_0010};
    tick();
    bus.inst_sram_addr_ok = 1'b0; br_bus = '0;
    bus.inst_sram_data_ok = 1'b1;
    tick();
    bus.inst_sram_data_ok = 1'b0;
    check("reqcan_valid", bus.fetch_valid, 0);
    issue(32'h8000_0010); respond(32'h8000_0010, 2'b11);

    // Branch while holding: pair invalidated
    br_bus = {1'b1, 32'h8000_0040};
    tick();
    br_bus = '0;
    check("hold_br_valid", bus.fetch_valid, 0);
    check("hold_br_addr", bus.inst_sram_addr, 32'h8000_0040);

    // Stall suppresses request; branch during stall is recorded
    stall_if = 1'b1;
    tick();
    check("stall_req", bus.inst_sram_req, 0);
    br_bus = {1'b1, 32'h8000_0080};
    tick();
    br_bus = '0;
    check("stall_br_req", bus.inst_sram_req, 0);
    stall_if = 1'b0;
    #1 check("stall_rel_addr", bus.inst_sram_addr, 32'h8000_0080);

    // Misaligned branch target -> S_ERR
    br_bus = {1'b1, 32'h8000_0002};
    tick();
    br_bus = '0;
    check("mis_req", bus.inst_sram_req, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      check("err_valid", bus.fetch_valid, 1);
      check("err_adel", bus.fetch_adel, 1);
      check("err_slot", bus.fetch_slot_val, 2'b01);
      check("err_inst", bus.fetch_inst, 0);
      check("err_pc", bus.fetch_pc, 32'h8000_0002);
      check("err_req", bus.inst_sram_req, 0);
      tick();
    end

    // Flush recovers; PC wraps modulo 2^32
    flush = 1'b1; flush_pc = 32'hFFFF_FFF8;
    tick();
    flush = 1'b0;
    check("rec_valid", bus.fetch_valid, 0);
    check("rec_adel", bus.fetch_adel, 0);
    issue(32'hFFFF_FFF8); respond(32'hFFFF_FFF8, 2'b11); accept();
    issue(32'h0000_0000);

    // Async reset mid-S_WAIT
    #2 rst = 1'b0;
    #1 check_all_zero("async_rst");
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_req", bus.inst_sram_req, 1);
    check("post_rst_addr", bus.inst_sram_addr, 32'hBFC0_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch-side producer for the dual-issue front end.
- Generates the PC and drives a request/addr_ok/data_ok handshake to the instruction SRAM, which returns one 64-bit word holding two instructions.
- Delivers each pair, with its PC and per-slot valid mask, to the ID-stage instruction buffer under valid/ready flow control.
- Redirects on branch (br_bus) or flush, and discards any response that was in flight at the redirect.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.
- FLUSH_PC_W, 32, width of the flush target PC.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- stall_if  in  1  pipeline stall to IF (stall[1]); 1 = issue no new SRAM request.
- flush  in  1  exception/eret redirect; highest priority.
- flush_pc  in  32  target for flush.
- br_bus  in  33  [32] branch taken, [31:0] target.
- inst_sram_req  out  1  request valid.
- inst_sram_addr  out  32  8-byte-aligned fetch address.
- inst_sram_addr_ok  in  1  request accepted this cycle.
- inst_sram_data_ok  in  1  response valid this cycle.
- inst_sram_rdata  in  64  [31:0] = inst @addr, [63:32] = inst @addr+4.
- fetch_valid  out  1  pair available to ID.
- fetch_ready  in  1  ID buffer can accept; the ID buffer drives this as ~buffer_full.
- fetch_pc  out  32  PC of slot 0 (the aligned address).
- fetch_inst  out  64  instruction pair.
- fetch_slot_val  out  2  per-slot valid; 2'b10 when the fetch started at pc[2]=1.
- fetch_adel  out  1  address-error flag for the pair (pc[1:0]!=0).

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, state=S_REQ, cancel=0.
  - All outputs 0, except inst_sram_addr=RESET_PC & ~7.
- States: S_REQ, S_WAIT, S_HOLD, S_ERR.
- S_REQ:
  - inst_sram_req = ~stall_if.
  - When req and addr_ok: latch pc into pc_inflight, pc <= (pc & ~7) + 8, go to S_WAIT.
  - If pc[1:0]!=0: issue no request, go to S_ERR.
- S_WAIT:
  - req=0; wait for data_ok.
  - On data_ok with cancel=0: capture rdata into the output register, go to S_HOLD. Latency is 1 cycle from data_ok to fetch_valid=1.
  - On data_ok with cancel=1: drop the data, clear cancel, go to S_REQ.
- S_HOLD:
  - fetch_valid=1, with fetch_pc, fetch_inst and slot_val held stable.
  - On fetch_valid & fetch_ready: transfer the pair, go to S_REQ.
  - Held data must not change while ready=0.
- S_ERR:
  - fetch_valid=1, fetch_adel=1, slot_val=2'b01, fetch_inst=0, fetch_pc=faulting pc.
  - Stays in S_ERR until flush.
- Slot mask:
  - slot_val = pc_inflight[2] ? 2'b10 : 2'b11.
  - fetch_pc always = pc_inflight & ~7.
- Redirect priority: flush > br_bus[32] > sequential.
  - pc <= flush ? flush_pc : br_bus[31:0].
  - In S_HOLD: the held pair is invalidated (fetch_valid=0 next cycle), go to S_REQ.
  - In S_WAIT: set cancel=1 and stay in S_WAIT until data_ok arrives.
  - In S_REQ with addr_ok in the same cycle: that request also counts as cancelled, so go to S_WAIT with cancel=1.
- Simultaneous data_ok and redirect in S_WAIT: the data is dropped and the redirect applies.
- At most one outstanding request at any time; req is never asserted in S_WAIT.
- A branch while stall_if=1 is still recorded: pc is updated and the request is issued once the stall drops.
- Wrap-around: pc arithmetic is modulo 2^32, so 32'hFFFF_FFF8 + 8 = 0.
- fetch_valid never depends combinationally on fetch_ready.

Decomposition:
- lib/defines.vh holds:
  - the state encodings S_REQ/S_WAIT/S_HOLD/S_ERR;
  - BR_WD=33 and the stall bit index;
  - a FETCH_TO_ID_WD constant = 1+32+64+2+1.
- One sub-module, fetch_pc_gen: holds pc and computes next_pc (sequential/branch/flush mux plus the alignment check).
- The handshake FSM and output register stay in inst_fetch_unit.

Test Plan:
- Reset then free-run: addr_ok=1 and data_ok one cycle later, ready=1 -> addresses BFC00000, BFC00008, BFC00010; fetch_pc matches each; slot_val=11.
- Backpressure: ready=0 for 5 cycles in S_HOLD -> fetch_inst stable, no new req; ready=1 -> next req at +8.
- Branch while in S_WAIT: target 0x80001004 -> the late data_ok is discarded (fetch_valid stays 0); next req addr 0x80001000; slot_val=10, fetch_pc=0x80001000.
- Flush and branch in the same cycle: flush_pc=0xBFC00380, br target 0x80000000 -> next req addr 0xBFC00380.
- Misaligned branch target 0x80000002 -> no req; fetch_valid=1, fetch_adel=1; a subsequent flush recovers.
- Async reset asserted mid-S_WAIT -> all outputs 0 immediately; after release, the first req is to RESET_PC.
